multicycle_datapath: RTL and testbench

MULTICYCLE_DATAPATH -- requirements
Module: multicycle_datapath

---
 rtl/multicycle_datapath_pkg.sv | 87 ++++++++
 rtl/multicycle_datapath_alu.sv | 40 ++++
 rtl/multicycle_datapath.sv | 80 ++++++++
 tb/tb_multicycle_datapath.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/multicycle_datapath_pkg.sv
// multicycle_datapath_pkg: control-word layout, mux/ALU encodings and opcodes shared by datapath and controller.
package multicycle_datapath_pkg;

    localparam int CW_PC_WRITE_COND = 15;
    localparam int CW_PC_WRITE      = 14;
    localparam int CW_I_OR_D        = 13;
    localparam int CW_MEM_READ      = 12;
    localparam int CW_MEM_WRITE     = 11;
    localparam int CW_MEM_TO_REG    = 10;
    localparam int CW_IR_WRITE      = 9;
    localparam int CW_PC_SOURCE     = 7;
    localparam int CW_ALU_OP        = 5;
    localparam int CW_ALU_SRC_B     = 3;
    localparam int CW_ALU_SRC_A     = 2;
    localparam int CW_REG_WRITE     = 1;
    localparam int CW_REG_DST       = 0;

    // Field order mirrors the bit indices above, MSB first.
    typedef struct packed {
        logic       pc_write_cond;
        logic       pc_write;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       ir_write;
        logic [1:0] pc_source;
        logic [1:0] alu_op;
        logic [1:0] alu_src_b;
        logic       alu_src_a;
        logic       reg_write;
        logic       reg_dst;
    } ctrl_t;

    localparam logic [1:0] PCS_ALU       = 2'b00;
    localparam logic [1:0] PCS_ALU_OUT   = 2'b01;
    localparam logic [1:0] PCS_JUMP      = 2'b10;
    localparam logic [1:0] PCS_ALU_OUT_2 = 2'b11;

    localparam logic [1:0] SRCB_REG       = 2'b00;
    localparam logic [1:0] SRCB_ONE       = 2'b01;
    localparam logic [1:0] SRCB_EXT_IMM   = 2'b10;
    localparam logic [1:0] SRCB_SEXT_IMM  = 2'b11;

    localparam logic [1:0] ALUOP_ADD  = 2'b00;
    localparam logic [1:0] ALUOP_FUNC = 2'b01;
    localparam logic [1:0] ALUOP_CMP  = 2'b10;
    localparam logic [1:0] ALUOP_IMM  = 2'b11;

    localparam logic [5:0] OP_NOOP  = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000001;
    localparam logic [5:0] OP_MOV   = 6'b010000;
    localparam logic [5:0] OP_NOT   = 6'b010001;
    localparam logic [5:0] OP_ADD   = 6'b010010;
    localparam logic [5:0] OP_SUB   = 6'b010011;
    localparam logic [5:0] OP_OR    = 6'b010100;
    localparam logic [5:0] OP_AND   = 6'b010101;
    localparam logic [5:0] OP_XOR   = 6'b010110;
    localparam logic [5:0] OP_SLT   = 6'b010111;
    localparam logic [5:0] OP_MOVI  = 6'b011000;
    localparam logic [5:0] OP_NOTI  = 6'b011001;
    localparam logic [5:0] OP_ADDI  = 6'b011010;
    localparam logic [5:0] OP_SUBI  = 6'b011011;
    localparam logic [5:0] OP_ORI   = 6'b011100;
    localparam logic [5:0] OP_ANDI  = 6'b011101;
    localparam logic [5:0] OP_XORI  = 6'b011110;
    localparam logic [5:0] OP_SLTI  = 6'b011111;
    localparam logic [5:0] OP_BNV   = 6'b100000;
    localparam logic [5:0] OP_BNE   = 6'b100001;
    localparam logic [5:0] OP_BLT   = 6'b100010;
    localparam logic [5:0] OP_BLE   = 6'b100011;
    localparam logic [5:0] OP_LW    = 6'b110000;
    localparam logic [5:0] OP_SW    = 6'b110001;
    localparam logic [5:0] OP_LI    = 6'b111000;
    localparam logic [5:0] OP_LWI   = 6'b111001;
    localparam logic [5:0] OP_SWI   = 6'b111010;

    function automatic logic imm_zero_ext(input logic [5:0] op);
        return op inside {OP_ORI, OP_ANDI, OP_XORI, OP_LI, OP_LWI, OP_SWI};
    endfunction

    // Absolute-address forms take the immediate as-is rather than offsetting a register.
    function automatic logic imm_absolute(input logic [5:0] op);
        return op inside {OP_LI, OP_LWI, OP_SWI};
    endfunction

endpackage

// File: rtl/multicycle_datapath_alu.sv
// dp_alu: combinational ALU and branch comparator for the multicycle datapath.
module dp_alu
    import multicycle_datapath_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [1:0]  alu_op,
    input  logic [5:0]  opcode,
    input  logic [15:0] imm,
    output logic [31:0] result,
    output logic        taken
);
    logic [31:0] func;
    logic [31:0] sext;
    logic        lt;
    logic        cond;

    always_comb begin
        sext = {{16{imm[15]}}, imm};
        lt   = $signed(a) < $signed(b);
        case (opcode[2:0])
            3'b000:  func = a;
            3'b001:  func = ~a;
            3'b010:  func = a + b;
            3'b011:  func = a - b;
            3'b100:  func = a | b;
            3'b101:  func = a & b;
            3'b110:  func = a ^ b;
            default: func = {31'b0, lt};
        endcase
        cond   = opcode[1:0] == 2'b01 ? (a != b) :
                 opcode[1:0] == 2'b10 ? lt :
                 opcode[1:0] == 2'b11 ? (lt || a == b) : 1'b0;
        taken  = alu_op == ALUOP_CMP && cond;
        result = alu_op == ALUOP_FUNC ? func :
                 alu_op == ALUOP_IMM  ? (imm_absolute(opcode) ? {16'b0, imm} : a + sext) :
                 a + b;
    end

endmodule

// File: rtl/multicycle_datapath.sv
// multicycle_datapath: PC/IR/MDR/A/B/ALUOut registers, register file and muxes driven by an external control word.
module multicycle_datapath
    import multicycle_datapath_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] ctrl,
    output logic [5:0]  opcode,
    output logic [31:0] mem_addr,
    output logic        mem_re,
    output logic        mem_we,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic [31:0] pc_dbg
);
    ctrl_t       c;
    logic [31:0] pc, ir, a, b, mdr, alu_out;
    logic [31:0] rf [32];
    logic [4:0]  r1, r2, r3, rd_a, rd_b, wr_idx;
    logic [31:0] ext_imm, src_a, src_b, alu_res, pc_next, wr_data;
    logic        taken, pair_sel;

    assign c      = ctrl_t'(ctrl);
    assign opcode = ir[31:26];
    assign r1     = ir[25:21];
    assign r2     = ir[20:16];
    assign r3     = ir[15:11];

    // Branches and SWI read their operands from the R1/R2 pair instead of R2/R3.
    assign pair_sel = opcode[5:4] == 2'b10 || opcode == OP_SWI;
    assign rd_a     = pair_sel ? r1 : r2;
    assign rd_b     = pair_sel ? r2 : r3;

    assign ext_imm = imm_zero_ext(opcode) ? {16'b0, ir[15:0]} : {{16{ir[15]}}, ir[15:0]};
    assign src_a   = c.alu_src_a ? a : pc;
    assign src_b   = c.alu_src_b == SRCB_REG     ? b :
                     c.alu_src_b == SRCB_ONE     ? 32'd1 :
                     c.alu_src_b == SRCB_EXT_IMM ? ext_imm : {{16{ir[15]}}, ir[15:0]};
    assign pc_next = c.pc_source == PCS_ALU  ? alu_res :
                     c.pc_source == PCS_JUMP ? {pc[31:26], ir[25:0]} : alu_out;
    assign wr_idx  = c.reg_dst ? r2 : r1;
    assign wr_data = c.mem_to_reg ? mdr : alu_out;

    assign mem_addr  = c.i_or_d ? alu_out : pc;
    assign mem_re    = c.mem_read && !reset;
    assign mem_we    = c.mem_write && !reset;
    assign mem_wdata = a;
    assign pc_dbg    = pc;

    dp_alu u_alu (
        .a      (src_a),
        .b      (src_b),
        .alu_op (c.alu_op),
        .opcode (opcode),
        .imm    (ir[15:0]),
        .result (alu_res),
        .taken  (taken)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            pc      <= '0;
            ir      <= '0;
            a       <= '0;
            b       <= '0;
            mdr     <= '0;
            alu_out <= '0;
            for (int i = 0; i < 32; i++) rf[i] <= '0;
        end else begin
            if (c.ir_write) ir <= mem_rdata;
            if (c.pc_write || (c.pc_write_cond && taken)) pc <= pc_next;
            if (c.reg_write) rf[wr_idx] <= wr_data;
            mdr     <= mem_rdata;
            a       <= rf[rd_a];
            b       <= rf[rd_b];
            alu_out <= alu_res;
        end
    end

endmodule

// File: tb/tb_multicycle_datapath.sv
// tb_multicycle_datapath: bench acts as the controller; an instruction-level model feeds a scoreboard checked by a monitor.
module tb_multicycle_datapath;
    import multicycle_datapath_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] ctrl = '0;
    logic [31:0] mem_rdata = '0;
    logic [5:0]  opcode;
    logic [31:0] mem_addr, mem_wdata, pc_dbg;
    logic        mem_re, mem_we;

    always #5 clk = ~clk;

    multicycle_datapath dut (
        .clk       (clk),
        .reset     (reset),
        .ctrl      (ctrl),
        .opcode    (opcode),
        .mem_addr  (mem_addr),
        .mem_re    (mem_re),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .pc_dbg    (pc_dbg)
    );

    function automatic logic [15:0] cw(input logic pcwc, pcw, iord, mr, mw, m2r, irw,
                                       input logic [1:0] pcs, aop, srcb,
                                       input logic srca, rw, rd);
        return {pcwc, pcw, iord, mr, mw, m2r, irw, pcs, aop, srcb, srca, rw, rd};
    endfunction

    localparam logic [15:0] FETCH  = cw(0, 1, 0, 1, 0, 0, 1, 2'b00, 2'b00, 2'b01, 0, 0, 0);
    localparam logic [15:0] DECODE = cw(0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b11, 0, 0, 0);
    localparam logic [15:0] EX_R   = cw(0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b00, 1, 0, 0);
    localparam logic [15:0] EX_I   = cw(0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, 1, 0, 0);
    localparam logic [15:0] EX_M   = cw(0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b11, 2'b00, 1, 0, 0);
    localparam logic [15:0] MEM_RD = cw(0, 0, 1, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0, 0);
    localparam logic [15:0] MEM_WR = cw(0, 0, 1, 0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0, 0);
    localparam logic [15:0] WB_ALU = cw(0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 1, 0);
    localparam logic [15:0] WB_MEM = cw(0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00, 0, 1, 0);
    localparam logic [15:0] EX_BR  = cw(1, 0, 0, 0, 0, 0, 0, 2'b01, 2'b10, 2'b00, 1, 0, 0);
    localparam logic [15:0] EX_J   = cw(0, 1, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b00, 0, 0, 0);
    localparam logic [15:0] EX_JR  = cw(0, 1, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b00, 1, 0, 0);

    localparam int S_PC = 0, S_OP = 1, S_ADDR = 2, S_RE = 3, S_WE = 4, S_WD = 5;

    typedef struct {
        int          cyc;
        int          sel;
        logic [31:0] exp;
        string       name;
    } exp_t;

    exp_t        sb[$];
    exp_t        e;
    logic [31:0] act;
    int          cyc = 0, checks = 0, errors = 0;
    logic [31:0] mpc;
    logic [31:0] mrf [32];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] pick(input int sel);
        case (sel)
            S_PC:    return pc_dbg;
            S_OP:    return {26'b0, opcode};
            S_ADDR:  return mem_addr;
            S_RE:    return {31'b0, mem_re};
            S_WE:    return {31'b0, mem_we};
            default: return mem_wdata;
        endcase
    endfunction

    // Monitor: compares everything the stimulus scheduled for the current cycle.
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e   = sb.pop_front();
            act = pick(e.sel);
            checks++;
            if (e.cyc != cyc || act !== e.exp) begin
                errors++;
                $display("FAIL %s cycle %0d: got %h, expected %h", e.name, cyc, act, e.exp);
            end
        end
    end

    function automatic logic [31:0] sx(input logic [15:0] i);
        return {{16{i[15]}}, i};
    endfunction

    function automatic logic [31:0] ref_alu(input logic [5:0] op, input logic [31:0] x, y);
        case (op[2:0])
            3'd0:    return x;
            3'd1:    return ~x;
            3'd2:    return x + y;
            3'd3:    return x - y;
            3'd4:    return x | y;
            3'd5:    return x & y;
            3'd6:    return x ^ y;
            default: return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
        endcase
    endfunction

    function automatic logic ref_taken(input logic [1:0] k, input logic [31:0] x, y);
        case (k)
            2'd1:    return x != y;
            2'd2:    return $signed(x) < $signed(y);
            2'd3:    return $signed(x) <= $signed(y);
            default: return 1'b0;
        endcase
    endfunction

    task automatic want(input int sel, input logic [31:0] v, input string n);
        exp_t x;
        x.cyc = cyc; x.sel = sel; x.exp = v; x.name = n;
        sb.push_back(x);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_rd(input logic [15:0] c, input logic [31:0] rd);
        ctrl = c;
        mem_rdata = rd;
    endtask

    task automatic drive(input logic [15:0] c);
        drive_rd(c, $urandom());
    endtask

    task automatic fetch(input logic [31:0] instr);
        drive_rd(FETCH, instr);
        want(S_ADDR, mpc, "fetch_addr");
        want(S_RE, 1, "fetch_re");
        tick();
        mpc = mpc + 1;
        want(S_OP, {26'b0, instr[31:26]}, "opcode");
        want(S_PC, mpc, "pc_inc");
    endtask

    task automatic decode();
        drive(DECODE);
        tick();
    endtask

    task automatic alu_instr(input logic [5:0] op, input logic [4:0] d, s, t, input logic [15:0] imm);
        logic [31:0] y;
        y = op[3] ? ((op inside {OP_ORI, OP_ANDI, OP_XORI}) ? {16'b0, imm} : sx(imm)) : mrf[t];
        fetch(op[3] ? {op, d, s, imm} : {op, d, s, t, 11'b0});
        decode();
        drive(op[3] ? EX_I : EX_R);
        tick();
        drive(WB_ALU);
        tick();
        mrf[d] = ref_alu(op, mrf[s], y);
    endtask

    task automatic load_reg(input logic [4:0] r, input logic [31:0] v, input logic [15:0] imm);
        fetch({OP_LWI, r, 5'd0, imm});
        decode();
        drive(EX_M);
        tick();
        drive_rd(MEM_RD, v);
        want(S_ADDR, {16'b0, imm}, "lwi_addr");
        want(S_RE, 1, "lwi_re");
        tick();
        drive(WB_MEM);
        tick();
        mrf[r] = v;
    endtask

    task automatic probe(input logic [4:0] r, input logic [15:0] imm);
        fetch({OP_SWI, r, 5'd0, imm});
        decode();
        drive(EX_M);
        tick();
        drive(MEM_WR);
        want(S_ADDR, {16'b0, imm}, "swi_addr");
        want(S_WE, 1, "swi_we");
        want(S_WD, mrf[r], "swi_wdata");
        tick();
    endtask

    task automatic branch(input logic [5:0] op, input logic [4:0] x, y, input logic [15:0] imm);
        fetch({op, x, y, imm});
        decode();
        drive(EX_BR);
        tick();
        if (ref_taken(op[1:0], mrf[x], mrf[y])) mpc = mpc + sx(imm);
        want(S_PC, mpc, "branch_pc");
    endtask

    task automatic set_pc(input logic [31:0] v);
        load_reg(5'd30, v, 16'($urandom()));
        fetch({OP_MOV, 5'd0, 5'd30, 16'b0});
        decode();
        drive(EX_JR);
        tick();
        mpc = v;
        want(S_PC, mpc, "set_pc");
    endtask

    task automatic jump(input logic [25:0] limm);
        fetch({OP_J, limm});
        drive(EX_J);
        tick();
        mpc = {mpc[31:26], limm};
        want(S_PC, mpc, "jump_pc");
    endtask

    task automatic model_reset();
        mpc = '0;
        for (int i = 0; i < 32; i++) mrf[i] = '0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        reset = 1'b1;
        drive(16'hFFFF);
        tick();
        tick();
        want(S_RE, 0, "rst_re");
        want(S_WE, 0, "rst_we");
        want(S_PC, 0, "rst_pc");
        want(S_OP, 0, "rst_opcode");
        tick();
        reset = 1'b0;

        fetch(32'h48430800);
        probe(5'd7, 16'h0040);

        load_reg(5'd3, 32'd5, 16'h0010);
        load_reg(5'd1, 32'd7, 16'h0011);
        alu_instr(OP_ADD, 5'd2, 5'd3, 5'd1, 16'h0);
        probe(5'd2, 16'h0020);
        alu_instr(OP_SUB, 5'd4, 5'd3, 5'd1, 16'h0);
        probe(5'd4, 16'h0021);

        load_reg(5'd1, 32'hFFFFFFFD, 16'h0030);
        load_reg(5'd2, 32'd2, 16'h0031);
        set_pc(32'd4);
        branch(OP_BLT, 5'd1, 5'd2, 16'hFFFE);
        load_reg(5'd1, 32'd3, 16'h0032);
        set_pc(32'd4);
        branch(OP_BLT, 5'd1, 5'd2, 16'hFFFE);

        set_pc(32'h8400000F);
        jump(26'h0000100);

        load_reg(5'd1, 32'hDEADBEEF, 16'h0001);
        probe(5'd1, 16'h8000);
        load_reg(5'd1, 32'h00001234, 16'h8000);
        probe(5'd1, 16'h0100);

        repeat (3) begin
            drive(16'h0000);
            tick();
        end
        want(S_PC, mpc, "idle_pc_hold");
        probe(5'd1, 16'h0101);

        repeat (60) begin
            case ($urandom_range(0, 3))
                0: load_reg(5'($urandom()), $urandom(), 16'($urandom()));
                1: alu_instr({2'b01, 1'($urandom()), 3'($urandom())}, 5'($urandom()),
                             5'($urandom()), 5'($urandom()), 16'($urandom()));
                2: branch({4'b1000, 2'($urandom())}, 5'($urandom()), 5'($urandom()), 16'($urandom()));
                default: probe(5'($urandom()), 16'($urandom()));
            endcase
        end

        load_reg(5'd5, 32'hCAFEF00D, 16'h0050);
        fetch({OP_LW, 5'd5, 5'd0, 16'h0010});
        decode();
        drive(EX_M);
        tick();
        reset = 1'b1;
        drive(MEM_RD);
        want(S_RE, 0, "rst_lw_re");
        want(S_WE, 0, "rst_lw_we");
        tick();
        reset = 1'b0;
        model_reset();
        want(S_PC, 0, "rst_lw_pc");
        want(S_OP, 0, "rst_lw_opcode");
        probe(5'd5, 16'h0060);

        drive(16'h0000);
        for (int i = 0; i < 20 && sb.size() > 0; i++) tick();
        if (sb.size() > 0) begin
            errors += sb.size();
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
